fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the five-stage pipelined MIPS core. Owns the PC, issues word reads to the instruction memory/icache, and presents the fetched instruction, its address and the JAL return address to the IF/ID pipeline register, along with that register's write-enable and flush controls. It absorbs memory latency, downstream stalls, control-flow redirects from later stages, and halt.

## Interface
Parameters:
- PCRESET, 32'h0000_0000: PC value after reset.

Ports:
- CLK  in  1  core clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction memory returns valid data this cycle.
- iload  in  32  instruction word from memory, valid when ihit.
- stall  in  1  hazard unit: IF/ID must hold.
- redirect  in  1  branch taken / jump resolved downstream.
- redirect_addr  in  32  target PC for redirect.
- halt  in  1  HALT has committed; stop fetching.
- iREN  out  1  instruction read enable.
- iaddr  out  32  read address (= PC).
- ifinstr  out  32  instruction to IF/ID.
- ifiaddr  out  32  PC of ifinstr.
- ifJALjump_addr  out  32  PC+4 of ifinstr.
- ifW  out  1  IF/ID write enable.
- ifRST  out  1  IF/ID flush (loads zero = nop).

## Operation
- States: FETCH, HOLD, HALTED. Reset: state=FETCH, PC=PCRESET, buffer=0.
- Event priority per cycle: RST > halt > redirect > stall > ihit.
- FETCH: iREN=1, iaddr=PC, ifinstr=iload.
  - ihit & !stall: ifW=1; PC<=PC+4; stay FETCH.
  - ihit & stall: buffer<=iload; ifW=0; go HOLD.
  - !ihit & !stall: ifRST=1 (bubble into IF/ID), ifW=0.
  - !ihit & stall: ifW=0, ifRST=0 (IF/ID holds).
- HOLD: iREN=0, ifinstr=buffer.
  - !stall: ifW=1; PC<=PC+4; go FETCH.
  - stall: hold everything.
- redirect (not halt), any state except HALTED: PC<=redirect_addr & ~32'h3; ifRST=1; ifW=0; buffer discarded; go FETCH. Overrides stall and ihit in the same cycle; a hit data word that cycle is dropped.
- halt: go HALTED; ifRST=1, ifW=0; PC frozen. HALTED: iREN=0, ifW=0, ifRST=0; exit only via RST.
- ifiaddr=PC and ifJALjump_addr=PC+4 in all states (HOLD keeps PC at buffered instruction's address).
- Arithmetic: 32-bit unsigned, PC+4 wraps 32'hFFFF_FFFC -> 32'h0000_0000. PC bits [1:0] always 00.
- ifW and ifRST are never both 1.

## Timing
- Outputs ifW/ifRST/ifinstr/iREN/iaddr are combinational from state, PC, buffer and inputs; PC/state/buffer registered.
- Latency: instruction at PC enters IF/ID on the rising edge ending the ihit cycle (zero wait) or the cycle stall drops (HOLD).
- Back-to-back hits with no stall: one instruction per cycle, PC advances by 4 each edge.
- First fetch from PCRESET issues in the cycle after RST deasserts.
- RST asserted mid-HOLD or mid-miss: next cycle state=FETCH, PC=PCRESET, buffer cleared, no IF/ID write that reset cycle (ifW=0, ifRST=0).

## Structure
- word_t (32-bit logic) and WORD_W come from cpu_types_pkg; add fetch_state_t enum {FETCH, HOLD, HALTED} there for bench visibility.
- One natural sub-module: pc_reg (PC register with load/increment/reset-value inputs). Buffer and FSM stay in fetch_unit.

## Test plan
- Reset then ihit=1 constantly, no stall -> iaddr 0,4,8,12 on successive cycles; ifW=1 each cycle; ifJALjump_addr = iaddr+4.
- ihit low 3 cycles at PC=0x10, stall=0 -> ifRST=1 for 3 cycles, PC stays 0x10; on 4th cycle hit ifW=1 and PC->0x14.
- ihit=1 with stall=1 for 2 cycles at PC=0x20, iload=0x8C220004 -> state HOLD, iREN=0, ifW=0; stall drops -> ifW=1, ifinstr=0x8C220004, ifiaddr=0x20, PC->0x24.
- In HOLD with stall=1, redirect=1, redirect_addr=0x103 -> ifRST=1, ifW=0; next cycle FETCH, iaddr=0x100, buffer discarded.
- halt=1 together with redirect=1 -> HALTED, ifRST=1 that cycle; afterwards iREN=0, ifW=0, PC frozen until RST.
- PCRESET=32'hFFFF_FFFC, one hit -> PC wraps to 0x0; RST during a miss -> PC returns to PCRESET next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared core types: machine word, fetch FSM states and PC helpers.
package cpu_types_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam word_t PC_STEP       = 32'h0000_0004;
  localparam word_t PC_ALIGN_MASK = 32'hFFFF_FFFC;

  // Sequential successor of a PC; wraps naturally at 32 bits.
  function automatic word_t pc_plus4(input word_t pc);
    return pc + PC_STEP;
  endfunction

  // Forces word alignment of an instruction address.
  function automatic word_t pc_align(input word_t addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: reset value, absolute load, or +4 increment.
// Every value written is word aligned so PC[1:0] stays 00.
module pc_reg
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  word_t reset_value,
  input  logic  load,
  input  word_t load_addr,
  input  logic  inc,
  output word_t pc,
  output word_t pc_next_seq
);

  assign pc_next_seq = pc_plus4(pc);

  // PC update: reset beats load, load beats increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= pc_align(reset_value);
    end else if (load) begin
      pc <= pc_align(load_addr);
    end else if (inc) begin
      pc <= pc_next_seq;
    end else begin
      pc <= pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads the instruction memory and
// feeds the IF/ID register, absorbing misses, stalls, redirects and halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PCRESET = 32'h0000_0000
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  word_t iload,
  input  logic  stall,
  input  logic  redirect,
  input  word_t redirect_addr,
  input  logic  halt,
  output logic  iREN,
  output word_t iaddr,
  output word_t ifinstr,
  output word_t ifiaddr,
  output word_t ifJALjump_addr,
  output logic  ifW,
  output logic  ifRST
);

  fetch_state_t state;
  fetch_state_t next_state;
  word_t        buffer;
  word_t        pc;
  word_t        pc_seq;
  logic         pc_load;
  logic         pc_inc;
  logic         buf_load;
  logic         buf_clear;

  pc_reg u_pc_reg (
    .clk         (CLK),
    .rst         (RST),
    .reset_value (PCRESET),
    .load        (pc_load),
    .load_addr   (redirect_addr),
    .inc         (pc_inc),
    .pc          (pc),
    .pc_next_seq (pc_seq)
  );

  // Address outputs always describe the instruction the PC points at;
  // in HOLD the PC has not moved, so it still names the buffered word.
  assign iaddr          = pc;
  assign ifiaddr        = pc;
  assign ifJALjump_addr = pc_seq;

  // Next-state and IF/ID control: RST > halt > redirect > stall > ihit.
  always_comb begin
    next_state = state;
    iREN       = 1'b0;
    ifinstr    = iload;
    ifW        = 1'b0;
    ifRST      = 1'b0;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    buf_load   = 1'b0;
    buf_clear  = 1'b0;
    if (RST) begin
      next_state = FETCH;
    end else begin
      case (state)
        FETCH: begin
          iREN = 1'b1;
          if (halt) begin
            next_state = HALTED;
            ifRST      = 1'b1;
          end else if (redirect) begin
            pc_load   = 1'b1;
            buf_clear = 1'b1;
            ifRST     = 1'b1;
          end else if (stall) begin
            // A hit under stall is parked so memory is not asked twice.
            if (ihit) begin
              buf_load   = 1'b1;
              next_state = HOLD;
            end else begin
              next_state = FETCH;
            end
          end else if (ihit) begin
            ifW    = 1'b1;
            pc_inc = 1'b1;
          end else begin
            // Miss with a free pipeline: push a bubble downstream.
            ifRST = 1'b1;
          end
        end
        HOLD: begin
          ifinstr = buffer;
          if (halt) begin
            next_state = HALTED;
            ifRST      = 1'b1;
          end else if (redirect) begin
            pc_load    = 1'b1;
            buf_clear  = 1'b1;
            ifRST      = 1'b1;
            next_state = FETCH;
          end else if (!stall) begin
            ifW        = 1'b1;
            pc_inc     = 1'b1;
            next_state = FETCH;
          end else begin
            next_state = HOLD;
          end
        end
        HALTED: begin
          next_state = HALTED;
        end
        default: begin
          next_state = FETCH;
        end
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Holding buffer for an instruction that arrived while IF/ID was stalled.
  always_ff @(posedge CLK) begin
    if (RST) begin
      buffer <= 32'h0000_0000;
    end else if (buf_clear) begin
      buffer <= 32'h0000_0000;
    end else if (buf_load) begin
      buffer <= iload;
    end else begin
      buffer <= buffer;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: the driver pushes hand-computed expected
// outputs per cycle, a negedge monitor pops and compares them.
module tb_fetch_unit;
  import cpu_types_pkg::*;

  localparam word_t RESET_PC = 32'hFFFF_FFFC;

  logic  CLK = 1'b0;
  logic  RST;
  logic  ihit;
  word_t iload;
  logic  stall;
  logic  redirect;
  word_t redirect_addr;
  logic  halt;
  logic  iREN;
  word_t iaddr;
  word_t ifinstr;
  word_t ifiaddr;
  word_t ifJALjump_addr;
  logic  ifW;
  logic  ifRST;

  fetch_unit #(.PCRESET(RESET_PC)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .iload          (iload),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .halt           (halt),
    .iREN           (iREN),
    .iaddr          (iaddr),
    .ifinstr        (ifinstr),
    .ifiaddr        (ifiaddr),
    .ifJALjump_addr (ifJALjump_addr),
    .ifW            (ifW),
    .ifRST          (ifRST)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic  iren;
    word_t iaddr;
    word_t jal;
    logic  w;
    logic  rst;
    word_t instr;
    logic  chk_instr;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  // Monitor: compares one expected record against the outputs of that cycle.
  always @(negedge CLK) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      logic  ok;
      e  = exp_q.pop_front();
      n  = name_q.pop_front();
      ok = (iREN === e.iren) && (iaddr === e.iaddr) && (ifiaddr === e.iaddr) &&
           (ifJALjump_addr === e.jal) && (ifW === e.w) && (ifRST === e.rst) &&
           (!e.chk_instr || (ifinstr === e.instr));
      total_cnt++;
      if (ok) begin
        pass_cnt++;
      end else begin
        $display("FAIL %s: got iREN=%b iaddr=%h ifiaddr=%h jal=%h ifW=%b ifRST=%b ifinstr=%h ; want iREN=%b iaddr=%h jal=%h ifW=%b ifRST=%b ifinstr=%h(chk=%b)",
                 n, iREN, iaddr, ifiaddr, ifJALjump_addr, ifW, ifRST, ifinstr,
                 e.iren, e.iaddr, e.jal, e.w, e.rst, e.instr, e.chk_instr);
      end
    end
  end

  task automatic drive(input logic r, input logic h, input word_t ld, input logic s,
                       input logic rd, input word_t ra, input logic hl);
    @(posedge CLK);
    #1;
    RST = r; ihit = h; iload = ld; stall = s;
    redirect = rd; redirect_addr = ra; halt = hl;
  endtask

  // One stimulus cycle plus its hand-computed expected response.
  task automatic step(input string nm,
                      input logic r, input logic h, input word_t ld, input logic s,
                      input logic rd, input word_t ra, input logic hl,
                      input logic e_iren, input word_t e_iaddr, input logic e_w,
                      input logic e_rst, input word_t e_instr, input logic e_chk);
    exp_t e;
    drive(r, h, ld, s, rd, ra, hl);
    e.iren = e_iren; e.iaddr = e_iaddr; e.jal = e_iaddr + 32'h0000_0004;
    e.w = e_w; e.rst = e_rst; e.instr = e_instr; e.chk_instr = e_chk;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  initial begin
    RST = 1'b1; ihit = 1'b0; iload = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_addr = 32'h0; halt = 1'b0;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    //    name            RST  ihit iload         stall redir raddr        halt  iREN iaddr         W     RST   instr         chk
    step("reset_state",   1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       1'b0);
    step("first_wrap",    1'b0, 1'b1, 32'hA000_0000, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'hA000_0000, 1'b1);
    step("hit_0",         1'b0, 1'b1, 32'hA000_0001, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 32'hA000_0001, 1'b1);
    step("hit_4",         1'b0, 1'b1, 32'hA000_0002, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0004, 1'b1, 1'b0, 32'hA000_0002, 1'b1);
    step("hit_8",         1'b0, 1'b1, 32'hA000_0003, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b0, 32'hA000_0003, 1'b1);
    step("hit_c",         1'b0, 1'b1, 32'hA000_0004, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_000C, 1'b1, 1'b0, 32'hA000_0004, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step("miss_bubble", 1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b1, 32'h0,       1'b1);
    end
    step("hit_after_miss",1'b0, 1'b1, 32'hB000_0010, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0010, 1'b1, 1'b0, 32'hB000_0010, 1'b1);
    step("redir_over_hit",1'b0, 1'b1, 32'hB000_0014, 1'b1, 1'b1, 32'h0000_0022, 1'b0, 1'b1, 32'h0000_0014, 1'b0, 1'b1, 32'hB000_0014, 1'b1);
    step("hit_stall",     1'b0, 1'b1, 32'h8C22_0004, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h8C22_0004, 1'b1);
    step("hold_stall",    1'b0, 1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0000_0020, 1'b0, 1'b0, 32'h8C22_0004, 1'b1);
    step("hold_release",  1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 32'h0000_0020, 1'b1, 1'b0, 32'h8C22_0004, 1'b1);
    step("hit_stall_24",  1'b0, 1'b1, 32'h1111_1111, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0024, 1'b0, 1'b0, 32'h1111_1111, 1'b1);
    step("hold_redirect", 1'b0, 1'b0, 32'h0,       1'b1, 1'b1, 32'h0000_0103, 1'b0, 1'b0, 32'h0000_0024, 1'b0, 1'b1, 32'h1111_1111, 1'b1);
    step("miss_stall_100",1'b0, 1'b0, 32'h3333_3333, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 32'h3333_3333, 1'b1);
    step("hit_100",       1'b0, 1'b1, 32'h2222_2222, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h2222_2222, 1'b1);
    step("halt_redirect", 1'b0, 1'b1, 32'h4444_4444, 1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 1'b1, 32'h4444_4444, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step("halted_frozen", 1'b0, 1'b1, 32'h5555_5555, 1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'h0,   1'b0);
    end
    step("rst_from_halt", 1'b1, 1'b1, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0104, 1'b0, 1'b0, 32'h0,       1'b0);
    step("refetch_reset", 1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h6666_6666, 1'b1);
    step("miss_at_0",     1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 32'h0,       1'b1);
    step("rst_mid_miss",  1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0,       1'b0);
    step("after_rst_miss",1'b0, 1'b0, 32'h0,       1'b0, 1'b0, 32'h0,       1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 32'h0,       1'b1);
    step("hit_stall_rst", 1'b0, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h7777_7777, 1'b1);
    step("rst_mid_hold",  1'b1, 1'b0, 32'h0,       1'b1, 1'b0, 32'h0,       1'b0, 1'b0, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,       1'b0);
    step("fetch_post_rst",1'b0, 1'b1, 32'h8888_8888, 1'b0, 1'b0, 32'h0,     1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h8888_8888, 1'b1);
    // Let the monitor drain; any record still queued after the budget is a failure.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      @(posedge CLK);
    end
    if (exp_q.size() > 0) begin
      $display("FAIL drain_timeout: %0d records unchecked, want 0", exp_q.size());
      total_cnt += exp_q.size();
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
